pc_fetch_ctrl: RTL

Program-counter register and IF/ID fetch-side controller for the 5-stage pipelined CPU. It consumes the ID-stage next-PC result (`npc`, `jmp`, `correct_b`) and turns it into PC updates, IF/ID loads and one-slot flushes. It also applies load-use stalls and implements the halt/resume state machine. It sits between instruction memory and the IF/ID boundary, and keeps saturating performance counters for taken branches, jumps and stall cycles.

---
 rtl/pc_fetch_ctrl_if.sv | 34 +++
 rtl/pc_fetch_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus between the PC/IF-ID controller and the rest of the pipeline.
// The master is the controller. The slave is the pipeline, instruction memory and debug side.
interface pc_fetch_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic             stall;
  logic [31:0]      imem_rdata;
  logic             jmp;
  logic             correct_b;
  logic [31:0]      npc;
  logic             halt;
  logic             go;
  logic [31:0]      pc;
  logic [31:0]      ifid_pc1;
  logic [31:0]      ifid_instr;
  logic             ifid_valid;
  logic             flush;
  logic             halted;
  logic [CNT_W-1:0] cnt_taken;
  logic [CNT_W-1:0] cnt_jump;
  logic [CNT_W-1:0] cnt_stall;

  modport master (
    input  stall, imem_rdata, jmp, correct_b, npc, halt, go,
    output pc, ifid_pc1, ifid_instr, ifid_valid, flush, halted,
           cnt_taken, cnt_jump, cnt_stall
  );

  modport slave (
    output stall, imem_rdata, jmp, correct_b, npc, halt, go,
    input  pc, ifid_pc1, ifid_instr, ifid_valid, flush, halted,
           cnt_taken, cnt_jump, cnt_stall
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC register and IF/ID fetch controller.
// It handles redirects with a one-slot flush, load-use stalls, halt/resume,
// and saturating counters for taken branches, jumps and stall cycles.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input logic             clk,
  input logic             rst_n,
  pc_fetch_ctrl_if.master bus
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic [31:0]      ifid_pc1_reg, ifid_pc1_next;
  logic [31:0]      ifid_instr_reg, ifid_instr_next;
  logic             ifid_valid_reg, ifid_valid_next;
  logic [CNT_W-1:0] cnt_taken_reg, cnt_taken_next;
  logic [CNT_W-1:0] cnt_jump_reg, cnt_jump_next;
  logic [CNT_W-1:0] cnt_stall_reg, cnt_stall_next;
  logic             flush_comb;
  logic             id_live;
  logic             redirect_req;
  logic             halt_req;
  logic [31:0]      pc_plus4;

  // A bubble in ID, or a stalled ID, can never redirect or halt.
  assign id_live      = ifid_valid_reg & ~bus.stall;
  // Halt wins over a redirect from the same instruction.
  assign redirect_req = id_live & (bus.jmp | bus.correct_b) & ~bus.halt;
  assign halt_req     = id_live & bus.halt;
  assign pc_plus4     = pc_reg + 32'd4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= RUN;
    else        state_reg <= state_next;
  end

  // Next-state logic: enter HALTED when a halt is accepted, and leave it on go.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (halt_req) state_next = HALTED;
      HALTED:  if (bus.go)   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Output/datapath logic: the priority order is stall, halt, redirect, then sequential fetch.
  always_comb begin
    pc_next         = pc_reg;
    ifid_pc1_next   = ifid_pc1_reg;
    ifid_instr_next = ifid_instr_reg;
    ifid_valid_next = ifid_valid_reg;
    cnt_taken_next  = cnt_taken_reg;
    cnt_jump_next   = cnt_jump_reg;
    cnt_stall_next  = cnt_stall_reg;
    flush_comb      = 1'b0;
    if (state_reg == RUN) begin
      if (bus.stall) begin
        cnt_stall_next = sat_inc(cnt_stall_reg);
      end else if (halt_req) begin
        // PC holds, so the instruction now in IF is refetched after resume.
        ifid_pc1_next   = 32'd0;
        ifid_instr_next = 32'd0;
        ifid_valid_next = 1'b0;
      end else if (redirect_req) begin
        flush_comb      = 1'b1;
        pc_next         = bus.npc;
        ifid_pc1_next   = 32'd0;
        ifid_instr_next = 32'd0;
        ifid_valid_next = 1'b0;
        if (bus.jmp) cnt_jump_next  = sat_inc(cnt_jump_reg);
        else         cnt_taken_next = sat_inc(cnt_taken_reg);
      end else begin
        pc_next         = pc_plus4;
        ifid_pc1_next   = pc_plus4;
        ifid_instr_next = bus.imem_rdata;
        ifid_valid_next = 1'b1;
      end
    end
  end

  // PC, IF/ID and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg         <= RESET_PC;
      ifid_pc1_reg   <= 32'd0;
      ifid_instr_reg <= 32'd0;
      ifid_valid_reg <= 1'b0;
      cnt_taken_reg  <= '0;
      cnt_jump_reg   <= '0;
      cnt_stall_reg  <= '0;
    end else begin
      pc_reg         <= pc_next;
      ifid_pc1_reg   <= ifid_pc1_next;
      ifid_instr_reg <= ifid_instr_next;
      ifid_valid_reg <= ifid_valid_next;
      cnt_taken_reg  <= cnt_taken_next;
      cnt_jump_reg   <= cnt_jump_next;
      cnt_stall_reg  <= cnt_stall_next;
    end
  end

  assign bus.pc         = pc_reg;
  assign bus.ifid_pc1   = ifid_pc1_reg;
  assign bus.ifid_instr = ifid_instr_reg;
  assign bus.ifid_valid = ifid_valid_reg;
  assign bus.flush      = flush_comb;
  assign bus.halted     = (state_reg == HALTED);
  assign bus.cnt_taken  = cnt_taken_reg;
  assign bus.cnt_jump   = cnt_jump_reg;
  assign bus.cnt_stall  = cnt_stall_reg;

endmodule
